i2s_tx: RTL

Master-mode I2S transmitter, the transmit counterpart to the SoC's I2S receive path. It takes stereo sample words from a small internal FIFO and generates BCLK, WS and serial data in standard Philips I2S format: MSB first, data one BCLK after each WS edge, data changing on the falling edge of BCLK. It sits on the SoC peripheral side, fed by the CPU or the DMAC. It also lets the bench loop audio back into the existing receiver without a behavioural model.

---
 rtl/i2s_pkg.sv | 29 ++
 rtl/i2s_tx_fifo.sv | 81 ++++++++
 rtl/i2s_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared I2S definitions used by the transmit and receive
//                paths: controller state encoding, default slot width and
//                bit-clock divider, and the frame-length helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Controller states, explicitly one bit wide.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } i2s_state_e;

    localparam int c_DEFAULT_SAMPLE_W = 16;
    localparam int c_DEFAULT_CLK_DIV  = 4;

    // One stereo frame is two channel slots.
    localparam int c_FRAME_LEN = 2 * c_DEFAULT_SAMPLE_W;

    function automatic int frame_len(input int sample_w);
        return 2 * sample_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head entry is
//                always visible on rdata; pop consumes it. Push while full and
//                pop while empty are ignored.
//  Ports       : clk    - clock, rising edge
//                rst    - asynchronous active-high reset (empties the FIFO)
//                push   - write request, qualified internally with !full
//                wdata  - write data
//                pop    - read request, qualified internally with !empty
//                rdata  - head entry
//                full   - no free entries
//                empty  - no occupied entries
//                level  - number of occupied entries
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign level     = r_count;
    assign rdata     = r_mem[r_rd_ptr];

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx
//  Description : Master-mode Philips I2S transmitter. Stereo words are
//                buffered in a small FIFO and shifted out MSB first, one BCLK
//                after each WS edge, with WS and data changing on the HCLK
//                edge where BCLK falls.
//  Ports       : HCLK       - clock, rising edge
//                HRESET     - asynchronous active-high reset
//                en         - run enable
//                wr_valid   - FIFO write request
//                wr_data    - {left, right} stereo word
//                wr_ready   - FIFO not full
//                fifo_level - occupied FIFO entries
//                bclk       - bit clock
//                ws         - word select (0 = left, 1 = right)
//                dout       - serial data
//                underrun   - one-cycle pulse when a frame load finds the
//                             FIFO empty
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W   = c_DEFAULT_SAMPLE_W,
    parameter int CLK_DIV    = c_DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          en,
    input  logic                          wr_valid,
    input  logic [2*SAMPLE_W-1:0]         wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          bclk,
    output logic                          ws,
    output logic                          dout,
    output logic                          underrun
);

    localparam int c_FRAME = frame_len(SAMPLE_W);
    localparam int c_BIT_W = $clog2(c_FRAME);
    localparam int c_DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_FRAME - 1);
    localparam logic [c_BIT_W-1:0] c_WS_LO    = c_BIT_W'(SAMPLE_W - 1);
    localparam logic [c_BIT_W-1:0] c_WS_HI    = c_BIT_W'(c_FRAME - 2);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    i2s_state_e          r_state;
    i2s_state_e          w_state_nxt;

    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [c_FRAME-1:0]  r_shift;
    logic                r_bclk;
    logic                r_ws;
    logic                r_underrun;

    logic                w_run;
    logic                w_div_wrap;
    logic                w_shift_tick;
    logic [c_BIT_W-1:0]  w_bit_nxt;
    logic                w_load;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_FRAME-1:0]  w_fifo_rdata;

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    i2s_tx_fifo #(
        .WIDTH (c_FRAME),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (wr_valid),
        .wdata (wr_data),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (fifo_level)
    );

    assign wr_ready = !w_fifo_full;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!en) w_state_nxt = ST_IDLE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Divider, bit counter and shifter
    // ------------------------------------------------------------------
    // Dropping en in RUN is treated exactly like IDLE on the same edge, so
    // the lines fall to zero immediately and the partial frame is discarded.
    assign w_run        = (r_state == ST_RUN) && en;
    assign w_div_wrap   = (r_div_cnt == c_DIV_LAST);
    assign w_shift_tick = w_run && w_div_wrap && r_bclk;
    assign w_bit_nxt    = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    assign w_load       = w_shift_tick && (w_bit_nxt == '0);
    assign w_pop        = w_load && !w_fifo_empty;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= c_BIT_LAST;
            r_shift    <= '0;
            r_bclk     <= 1'b0;
            r_ws       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (!w_run) begin
                // Held at the start-of-run values, so entering RUN begins a
                // fresh frame two half-periods later.
                r_div_cnt <= '0;
                r_bit_cnt <= c_BIT_LAST;
                r_shift   <= '0;
                r_bclk    <= 1'b0;
                r_ws      <= 1'b0;
            end else begin
                r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
                if (w_div_wrap) begin
                    r_bclk <= ~r_bclk;
                end
                if (w_shift_tick) begin
                    r_bit_cnt <= w_bit_nxt;
                    // WS switches one bit ahead of each channel's MSB.
                    r_ws      <= (w_bit_nxt >= c_WS_LO) && (w_bit_nxt <= c_WS_HI);
                    if (w_load) begin
                        r_shift    <= w_fifo_empty ? '0 : w_fifo_rdata;
                        r_underrun <= w_fifo_empty;
                    end else begin
                        r_shift <= {r_shift[c_FRAME-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bclk     = r_bclk;
    assign ws       = r_ws;
    assign dout     = r_shift[c_FRAME-1];
    assign underrun = r_underrun;

endmodule
`default_nettype wire
